// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared types for the reset sequencer.
// Holds the FSM state encoding and the lock-loss counter width.
package reset_seq_pkg;

    localparam int LOST_CNT_W = 8;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        RELEASE   = 2'd1,
        RUN       = 2'd2,
        SW_HOLD   = 2'd3
    } rs_state_e;

    // Saturating increment for the lock-loss counter.
    function automatic logic [LOST_CNT_W-1:0] sat_inc(
        input logic [LOST_CNT_W-1:0] v
    );
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sync_level.sv
// sync_level: N-flop level synchronizer for a slow async status bit.
// Ports: clk, rst (sync, active-high), d (async in), q (synced out).
module sync_level #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    // Depth below two gives no metastability margin; clamp it.
    localparam int N = (STAGES < 2) ? 2 : STAGES;

    (* ASYNC_REG = "TRUE" *)
    logic [N-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[N-2:0], d};
        end
    end

    assign q = chain[N-1];

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: staggered per-block reset release gated by PLL lock.
// Ports: clk, rst (sync, active-high), pll_locked (async level),
//   sw_rst_req (1-cycle pulse), rst_out[N_STAGES] (active-high),
//   ready, lock_lost_cnt[8], lock_timeout (sticky), state_o[2].
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int N_STAGES     = 3,
    parameter int SYNC_STAGES  = 2,
    parameter int HOLD_CYCLES  = 16,
    parameter int STAGE_GAP    = 8,
    parameter int LOCK_TIMEOUT = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pll_locked,
    input  logic                  sw_rst_req,
    output logic [N_STAGES-1:0]   rst_out,
    output logic                  ready,
    output logic [LOST_CNT_W-1:0] lock_lost_cnt,
    output logic                  lock_timeout,
    output logic [1:0]            state_o
);

    localparam int STB_W = $clog2(HOLD_CYCLES + 1);
    localparam int GAP_W = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam int TO_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam int IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

    localparam logic [STB_W-1:0] HOLD_MAX  = STB_W'(HOLD_CYCLES);
    localparam logic [STB_W-1:0] HOLD_LAST = STB_W'(HOLD_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(STAGE_GAP - 1);
    localparam logic [TO_W-1:0]  TO_MAX    = TO_W'(LOCK_TIMEOUT);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_STAGES - 1);

    localparam logic [N_STAGES-1:0] ALL_ON    = '1;
    localparam logic [N_STAGES-1:0] FIRST_OFF = ALL_ON << 1;
    localparam logic [N_STAGES-1:0] ONE_HOT0  = N_STAGES'(1);

    localparam logic SINGLE = (N_STAGES == 1);

    logic lock_s;

    rs_state_e        state;
    logic [STB_W-1:0] stb_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [IDX_W-1:0] stage_idx;

    sync_level #(
        .STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk(clk),
        .rst(rst),
        .d  (pll_locked),
        .q  (lock_s)
    );

    assign state_o = state;

    // stb_cnt doubles as the SW_HOLD duration counter; it is
    // always cleared on the way into and out of SW_HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= WAIT_LOCK;
            stb_cnt       <= '0;
            gap_cnt       <= '0;
            to_cnt        <= '0;
            stage_idx     <= '0;
            rst_out       <= ALL_ON;
            ready         <= 1'b0;
            lock_lost_cnt <= '0;
            lock_timeout  <= 1'b0;
        end else begin
            unique case (state)
                WAIT_LOCK: begin
                    rst_out <= ALL_ON;
                    ready   <= 1'b0;
                    if (to_cnt != TO_MAX) begin
                        to_cnt <= to_cnt + 1'b1;
                        if (to_cnt == TO_MAX - 1'b1) begin
                            lock_timeout <= 1'b1;
                        end
                    end
                    if (!lock_s || sw_rst_req) begin
                        stb_cnt <= '0;
                    end else if (stb_cnt == HOLD_MAX) begin
                        // Lock qualified: first stage goes now.
                        stb_cnt   <= '0;
                        to_cnt    <= '0;
                        gap_cnt   <= '0;
                        stage_idx <= IDX_W'(1);
                        rst_out   <= FIRST_OFF;
                        ready     <= SINGLE;
                        state     <= SINGLE ? RUN : RELEASE;
                    end else begin
                        stb_cnt <= stb_cnt + 1'b1;
                    end
                end

                RELEASE: begin
                    to_cnt <= '0;
                    if (!lock_s) begin
                        rst_out       <= ALL_ON;
                        ready         <= 1'b0;
                        lock_lost_cnt <= sat_inc(lock_lost_cnt);
                        stb_cnt       <= '0;
                        gap_cnt       <= '0;
                        state         <= WAIT_LOCK;
                    end else if (sw_rst_req) begin
                        rst_out <= ALL_ON;
                        ready   <= 1'b0;
                        stb_cnt <= '0;
                        gap_cnt <= '0;
                        state   <= SW_HOLD;
                    end else if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        rst_out <= rst_out & ~(ONE_HOT0 << stage_idx);
                        if (stage_idx == IDX_LAST) begin
                            ready <= 1'b1;
                            state <= RUN;
                        end else begin
                            stage_idx <= stage_idx + 1'b1;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                RUN: begin
                    to_cnt <= '0;
                    if (!lock_s) begin
                        rst_out       <= ALL_ON;
                        ready         <= 1'b0;
                        lock_lost_cnt <= sat_inc(lock_lost_cnt);
                        stb_cnt       <= '0;
                        gap_cnt       <= '0;
                        state         <= WAIT_LOCK;
                    end else if (sw_rst_req) begin
                        rst_out <= ALL_ON;
                        ready   <= 1'b0;
                        stb_cnt <= '0;
                        gap_cnt <= '0;
                        state   <= SW_HOLD;
                    end else begin
                        rst_out <= '0;
                        ready   <= 1'b1;
                    end
                end

                SW_HOLD: begin
                    rst_out <= ALL_ON;
                    ready   <= 1'b0;
                    to_cnt  <= '0;
                    // Lock loss here is not counted: the blocks are
                    // already held in reset by software.
                    if (!lock_s || stb_cnt == HOLD_LAST) begin
                        stb_cnt <= '0;
                        state   <= WAIT_LOCK;
                    end else begin
                        stb_cnt <= stb_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed checks of reset_sequencer.
// Main DUT uses defaults; a second DUT uses LOCK_TIMEOUT=100.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       sw_rst_req;
    logic [2:0] rst_out;
    logic       ready;
    logic [7:0] lock_lost_cnt;
    logic       lock_timeout;
    logic [1:0] state_o;

    logic       t_rst;
    logic       t_pll;
    logic       t_sw;
    logic [2:0] t_rst_out;
    logic       t_ready;
    logic [7:0] t_cnt;
    logic       t_timeout;
    logic [1:0] t_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reset_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .sw_rst_req   (sw_rst_req),
        .rst_out      (rst_out),
        .ready        (ready),
        .lock_lost_cnt(lock_lost_cnt),
        .lock_timeout (lock_timeout),
        .state_o      (state_o)
    );

    reset_sequencer #(
        .LOCK_TIMEOUT(100)
    ) dut_to (
        .clk          (clk),
        .rst          (t_rst),
        .pll_locked   (t_pll),
        .sw_rst_req   (t_sw),
        .rst_out      (t_rst_out),
        .ready        (t_ready),
        .lock_lost_cnt(t_cnt),
        .lock_timeout (t_timeout),
        .state_o      (t_state)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Staggered release; pre = ticks to the last all-held sample.
    task automatic rel_seq(input string tag, input int pre);
        tick(pre);
        chk({tag, "_held"}, 32'(rst_out), 32'h7);
        tick(1);
        chk({tag, "_s0"}, 32'(rst_out), 32'h6);
        chk({tag, "_st1"}, 32'(state_o), 32'd1);
        tick(7);
        chk({tag, "_s0b"}, 32'(rst_out), 32'h6);
        tick(1);
        chk({tag, "_s1"}, 32'(rst_out), 32'h4);
        tick(7);
        chk({tag, "_s1rdy"}, 32'(ready), 32'd0);
        tick(1);
        chk({tag, "_s2"}, 32'(rst_out), 32'h0);
        chk({tag, "_rdy"}, 32'(ready), 32'd1);
        chk({tag, "_st2"}, 32'(state_o), 32'd2);
    endtask

    task automatic wait_state(input string tag, input logic [1:0] s,
                              input int max);
        for (int i = 0; i < max; i++) begin
            if (state_o == s) break;
            tick(1);
        end
        chk(tag, 32'(state_o), 32'(s));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        pll_locked = 1'b0;
        sw_rst_req = 1'b0;
        t_rst      = 1'b1;
        t_pll      = 1'b0;
        t_sw       = 1'b0;

        // Power-up
        tick(5);
        chk("rst_out_rst", 32'(rst_out), 32'h7);
        chk("ready_rst", 32'(ready), 32'd0);
        chk("cnt_rst", 32'(lock_lost_cnt), 32'd0);
        chk("to_rst", 32'(lock_timeout), 32'd0);
        chk("state_rst", 32'(state_o), 32'd0);
        rst = 1'b0;
        tick(3);
        pll_locked = 1'b1;
        rel_seq("pwr", 18);

        // Lock loss in RUN
        tick(4);
        pll_locked = 1'b0;
        tick(2);
        chk("loss_early", 32'(rst_out), 32'h0);
        tick(1);
        chk("loss_rst", 32'(rst_out), 32'h7);
        chk("loss_rdy", 32'(ready), 32'd0);
        chk("loss_cnt", 32'(lock_lost_cnt), 32'd1);
        chk("loss_st", 32'(state_o), 32'd0);
        tick(7);
        pll_locked = 1'b1;
        rel_seq("relock", 18);

        // Software reset in RUN
        tick(3);
        sw_rst_req = 1'b1;
        tick(1);
        sw_rst_req = 1'b0;
        chk("sw_rst", 32'(rst_out), 32'h7);
        chk("sw_st", 32'(state_o), 32'd3);
        tick(15);
        chk("sw_hold", 32'(state_o), 32'd3);
        tick(1);
        chk("sw_wait", 32'(state_o), 32'd0);
        rel_seq("sw", 16);
        chk("sw_cnt", 32'(lock_lost_cnt), 32'd1);

        // sw_rst_req coincident with lock loss
        tick(2);
        pll_locked = 1'b0;
        tick(2);
        sw_rst_req = 1'b1;
        tick(1);
        sw_rst_req = 1'b0;
        chk("sim_st", 32'(state_o), 32'd0);
        chk("sim_cnt", 32'(lock_lost_cnt), 32'd2);
        chk("sim_rst", 32'(rst_out), 32'h7);
        tick(3);

        // Lock loss mid-RELEASE
        pll_locked = 1'b1;
        tick(19);
        chk("mid_s0", 32'(rst_out), 32'h6);
        pll_locked = 1'b0;
        tick(2);
        chk("mid_hold", 32'(rst_out), 32'h6);
        tick(1);
        chk("mid_rst", 32'(rst_out), 32'h7);
        chk("mid_st", 32'(state_o), 32'd0);
        chk("mid_cnt", 32'(lock_lost_cnt), 32'd3);

        // Saturation: 257 more losses, 260 total
        for (int i = 0; i < 257; i++) begin
            pll_locked = 1'b1;
            wait_state("sat_rel", 2'd1, 40);
            pll_locked = 1'b0;
            wait_state("sat_wait", 2'd0, 10);
        end
        chk("sat_cnt", 32'(lock_lost_cnt), 32'd255);
        chk("sat_to", 32'(lock_timeout), 32'd0);

        // One-cycle reset mid-operation
        pll_locked = 1'b1;
        wait_state("pre_rst_rel", 2'd1, 40);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("r_cnt", 32'(lock_lost_cnt), 32'd0);
        chk("r_to", 32'(lock_timeout), 32'd0);
        chk("r_rst", 32'(rst_out), 32'h7);
        chk("r_rdy", 32'(ready), 32'd0);
        chk("r_st", 32'(state_o), 32'd0);

        // Unstable lock and timeout on the LOCK_TIMEOUT=100 DUT
        t_rst = 1'b0;
        for (int k = 0; k < 130; k++) begin
            t_pll = ((k % 13) < 10);
            tick(1);
            if (k == 98) chk("to_99", 32'(t_timeout), 32'd0);
            if (k == 99) chk("to_100", 32'(t_timeout), 32'd1);
        end
        chk("unst_rst", 32'(t_rst_out), 32'h7);
        chk("unst_cnt", 32'(t_cnt), 32'd0);
        t_pll = 1'b1;
        tick(40);
        chk("to_lock_rdy", 32'(t_ready), 32'd1);
        chk("to_sticky", 32'(t_timeout), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Consumer side of the clock/reset generation path. Runs in the sys clock domain and takes the asynchronous Ethernet PLL lock status plus a software reset request.
- Releases per-block resets in a fixed, staggered order. Re-asserts all of them on lock loss or software request.
- Reports health: ready, a lock-loss count and a sticky lock timeout. Sits between the PLL block and the datapath blocks: MAC, crypto, CSR.

Parameters:
- N_STAGES, 3: number of ordered reset outputs; stage 0 is released first.
- SYNC_STAGES, 2: flop depth of the lock-input synchronizer; minimum 2.
- HOLD_CYCLES, 16: consecutive cycles synchronized lock must stay high before release starts. Also the reset pulse length after a software request.
- STAGE_GAP, 8: cycles between consecutive stage releases; minimum 1.
- LOCK_TIMEOUT, 1000000: cycles in WAIT_LOCK before lock_timeout is flagged.

Ports:
- clk  in  1  sys clock.
- rst  in  1  synchronous, active-high reset.
- pll_locked  in  1  asynchronous PLL lock status (level).
- sw_rst_req  in  1  software reset request, single-cycle pulse, clk domain.
- rst_out  out  N_STAGES  per-stage reset, active-high.
- ready  out  1  all stages released, state RUN.
- lock_lost_cnt  out  8  number of lock losses seen in RELEASE/RUN; saturates at 255.
- lock_timeout  out  1  sticky; lock not achieved within LOCK_TIMEOUT.
- state_o  out  2  current FSM state, for debug/CSR.

Behaviour:
- Clocking and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values (rst=1):
  - rst_out all 1s, ready=0, lock_lost_cnt=0, lock_timeout=0.
  - Synchronizer flops 0, all counters 0, state WAIT_LOCK.
- Synchronization: pll_locked passes through a SYNC_STAGES flop chain to give lock_s. Only lock_s is used internally.
- States and encoding: WAIT_LOCK=0, RELEASE=1, RUN=2, SW_HOLD=3.
- WAIT_LOCK:
  - rst_out all 1s, ready=0.
  - The stable counter increments on each cycle lock_s=1 and clears on lock_s=0.
  - When lock_s has been 1 for HOLD_CYCLES consecutive cycles, go to RELEASE. rst_out[0] deasserts at that same edge.
  - Timing contract: with pll_locked sampled 1 first at edge t0 and held, rst_out[0] falls at edge t0+SYNC_STAGES+HOLD_CYCLES.
  - The timeout counter counts cycles since entry to WAIT_LOCK and saturates. Reaching LOCK_TIMEOUT sets lock_timeout, which stays set until rst.
  - sw_rst_req here only clears the stable counter.
- RELEASE:
  - rst_out[k] deasserts STAGE_GAP*k cycles after rst_out[0].
  - Once released, a stage stays released until a re-assert event.
  - ready rises at the same edge rst_out[N_STAGES-1] falls; state goes to RUN.
  - N_STAGES=1: go straight to RUN with ready at the same edge.
- RUN: rst_out all 0s, ready=1.
- Lock loss (lock_s=0 while in RELEASE or RUN):
  - At the next edge: rst_out all 1s, ready=0, lock_lost_cnt += 1 (saturating), state WAIT_LOCK.
  - Stable and timeout counters cleared.
- Software request (sw_rst_req=1 in RELEASE or RUN, lock_s=1):
  - At the next edge: rst_out all 1s, ready=0, state SW_HOLD.
  - SW_HOLD lasts exactly HOLD_CYCLES cycles, then goes to WAIT_LOCK. A full HOLD_CYCLES lock qualification is needed again.
- Simultaneous events:
  - Lock loss wins over sw_rst_req; the counter increments and the next state is WAIT_LOCK.
  - Lock loss during SW_HOLD: go to WAIT_LOCK immediately; no counter increment.
  - sw_rst_req during SW_HOLD is ignored.
- Reset mid-operation: rst has priority over everything; all outputs return to their reset values at that edge.
- Widths:
  - Stable counter sized for HOLD_CYCLES, clamped.
  - Gap counter sized for STAGE_GAP.
  - Timeout counter is $clog2(LOCK_TIMEOUT+1) bits and saturates.
  - Stage index is $clog2(N_STAGES) bits, minimum 1.
- Registering: all outputs are registered and there are no combinational paths from inputs to outputs. A lock_s glitch shorter than one cycle after synchronization can be missed; this is by design.

Decomposition:
- Package reset_seq_pkg holds the state enum type (2 bits, encodings above) and the lock_lost_cnt width constant (8).
- One sub-module: sync_level, a parameterized N-flop level synchronizer carrying an ASYNC_REG attribute. It is instantiated once for pll_locked.

Test Plan:
- Power-up: rst high 5 cycles, then low; pll_locked rises at edge t0 and holds (defaults).
  - Expect rst_out=3'b111 until t0+18.
  - Then rst_out[0] falls at t0+18, [1] at t0+26, [2] at t0+34.
  - ready rises at t0+34; state_o sequence 0,1,2.
- Lock loss in RUN: drop pll_locked for 10 cycles.
  - Exactly SYNC_STAGES+1 edges after the drop, expect rst_out=3'b111, ready=0, lock_lost_cnt=1.
  - After relock, the full sequence repeats with identical 18/26/34 offsets.
- Unstable lock: toggle pll_locked high 10 cycles / low 3 cycles, repeated.
  - rst_out stays 3'b111 and lock_lost_cnt stays 0.
  - With LOCK_TIMEOUT=100 override, lock_timeout=1 after 100 cycles in WAIT_LOCK and stays 1 after later lock.
- Software reset: sw_rst_req pulse in RUN.
  - Next edge rst_out=3'b111 and state_o=3.
  - 16 cycles later state_o=0; release begins after 16 qualifying cycles; lock_lost_cnt unchanged.
- Simultaneous events: pulse sw_rst_req in the same cycle lock_s falls.
  - Expect state WAIT_LOCK (not SW_HOLD) and lock_lost_cnt increments.
  - Drop lock in mid-RELEASE (after stage 0 only released): all stages re-assert next edge.
- Saturation and reset: force 260 lock losses, expecting lock_lost_cnt=255. Then assert rst for 1 cycle, expecting all counters 0, lock_timeout=0 and rst_out=3'b111.
